// File: rtl/fpnew_reorder_buffer.sv
// In-order writeback buffer behind the FPU: tags issue, captures out-of-order
// completions and retires results strictly in issue order with sticky fflags.
module fpnew_reorder_buffer #(
    parameter int unsigned Width = 64,
    parameter int unsigned Depth = 8,
    localparam int unsigned TagWidth = $clog2(Depth)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    input  logic                alloc_valid_i,
    output logic                alloc_ready_o,
    output logic [TagWidth-1:0] alloc_tag_o,
    input  logic                fpu_valid_i,
    output logic                fpu_ready_o,
    input  logic [Width-1:0]    fpu_result_i,
    input  logic [4:0]          fpu_status_i,
    input  logic [TagWidth-1:0] fpu_tag_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [Width-1:0]    result_o,
    output logic [4:0]          status_o,
    output logic [4:0]          fflags_o,
    input  logic                fflags_clr_i,
    output logic                empty_o,
    output logic                err_o
);

    logic [TagWidth:0]   wr_ptr, rd_ptr, count;
    logic [TagWidth-1:0] rd_idx, wr_idx, cpl_off;
    logic [Depth-1:0]    done;
    logic [Width-1:0]    res_q [Depth];
    logic [4:0]          st_q  [Depth];
    logic                full, alloc, retire, cpl_hit, cpl_ok, cpl_bad;

    assign rd_idx = rd_ptr[TagWidth-1:0];
    assign wr_idx = wr_ptr[TagWidth-1:0];
    assign count  = wr_ptr - rd_ptr;
    assign full   = (rd_idx == wr_idx) && (rd_ptr[TagWidth] != wr_ptr[TagWidth]);

    assign empty_o       = (rd_ptr == wr_ptr);
    assign alloc_ready_o = !full;
    assign alloc_tag_o   = wr_idx;
    assign fpu_ready_o   = 1'b1;
    assign out_valid_o   = !empty_o && done[rd_idx];
    assign result_o      = res_q[rd_idx];
    assign status_o      = st_q[rd_idx];

    // Distance from the head, modulo Depth, tells whether the tag is in flight
    assign cpl_off = fpu_tag_i - rd_idx;
    assign cpl_hit = ({1'b0, cpl_off} < count) && !done[fpu_tag_i];
    assign cpl_ok  = fpu_valid_i && !flush_i && cpl_hit;
    assign cpl_bad = fpu_valid_i && !flush_i && !cpl_hit;

    assign alloc  = alloc_valid_i && !full && !flush_i;
    assign retire = out_valid_o && out_ready_i && !flush_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            done     <= '0;
            fflags_o <= '0;
            err_o    <= 1'b0;
        end else begin
            if (cpl_bad) err_o <= 1'b1;
            if (retire) begin
                fflags_o <= (fflags_clr_i ? 5'b0 : fflags_o) | status_o;
            end else if (fflags_clr_i) begin
                fflags_o <= '0;
            end
            if (flush_i) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                done   <= '0;
            end else begin
                if (alloc) wr_ptr <= wr_ptr + 1'b1;
                if (retire) begin
                    rd_ptr       <= rd_ptr + 1'b1;
                    done[rd_idx] <= 1'b0;
                end
                if (cpl_ok) done[fpu_tag_i] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (cpl_ok) begin
            res_q[fpu_tag_i] <= fpu_result_i;
            st_q[fpu_tag_i]  <= fpu_status_i;
        end
    end

endmodule

// File: tb/tb_fpnew_reorder_buffer.sv
// Bench for fpnew_reorder_buffer: directed scenarios plus random traffic
// checked against an occupancy/array model of the buffer.
module tb_fpnew_reorder_buffer;

    localparam int W  = 64;
    localparam int D  = 8;
    localparam int TW = $clog2(D);

    logic          clk, rst_n, flush, alloc_valid, alloc_ready;
    logic [TW-1:0] alloc_tag, fpu_tag;
    logic          fpu_valid, fpu_ready, out_valid, out_ready;
    logic [W-1:0]  fpu_result, result;
    logic [4:0]    fpu_status, status, fflags;
    logic          fflags_clr, empty, err;

    fpnew_reorder_buffer #(.Width(W), .Depth(D)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .alloc_valid_i(alloc_valid), .alloc_ready_o(alloc_ready),
        .alloc_tag_o(alloc_tag), .fpu_valid_i(fpu_valid),
        .fpu_ready_o(fpu_ready), .fpu_result_i(fpu_result),
        .fpu_status_i(fpu_status), .fpu_tag_i(fpu_tag),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .result_o(result), .status_o(status), .fflags_o(fflags),
        .fflags_clr_i(fflags_clr), .empty_o(empty), .err_o(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: head index, occupancy count and per-entry arrays
    int         m_head, m_count;
    bit         m_done [D];
    logic [W-1:0] m_res [D];
    logic [4:0] m_st [D];
    logic [4:0] m_fflags;
    bit         m_err;

    task automatic compare_all();
        bit ov;
        ov = (m_count > 0) && m_done[m_head];
        check("alloc_ready", 64'(alloc_ready), 64'(m_count < D));
        check("alloc_tag", 64'(alloc_tag), 64'((m_head + m_count) % D));
        check("out_valid", 64'(out_valid), 64'(ov));
        check("empty", 64'(empty), 64'(m_count == 0));
        check("fflags", 64'(fflags), 64'(m_fflags));
        check("err", 64'(err), 64'(m_err));
        check("fpu_ready", 64'(fpu_ready), 64'd1);
        if (ov) begin
            check("result", result, m_res[m_head]);
            check("status", 64'(status), 64'(m_st[m_head]));
        end
    endtask

    task automatic cycle(input bit av, input bit fv, input logic [TW-1:0] tg,
                         input logic [W-1:0] res, input logic [4:0] st,
                         input bit ordy, input bit clr, input bit fl);
        bit ret, al;
        int off;
        alloc_valid = av; fpu_valid = fv; fpu_tag = tg;
        fpu_result = res; fpu_status = st; out_ready = ordy;
        fflags_clr = clr; flush = fl;
        if (fl) begin
            m_head = 0; m_count = 0;
            foreach (m_done[i]) m_done[i] = 0;
            if (clr) m_fflags = '0;
        end else begin
            ret = (m_count > 0) && m_done[m_head] && ordy;
            al  = av && (m_count < D);
            if (fv) begin
                off = (int'(tg) - m_head + D) % D;
                if (off < m_count && !m_done[tg]) begin
                    m_done[tg] = 1; m_res[tg] = res; m_st[tg] = st;
                end else begin
                    m_err = 1;
                end
            end
            if (ret) begin
                m_fflags = (clr ? 5'b0 : m_fflags) | m_st[m_head];
                m_done[m_head] = 0;
                m_head = (m_head + 1) % D;
                m_count--;
            end else if (clr) begin
                m_fflags = '0;
            end
            if (al) m_count++;
        end
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input bit ordy);
        cycle(0, 0, '0, '0, '0, ordy, 0, 0);
    endtask

    task automatic cpl(input logic [TW-1:0] tg, input logic [W-1:0] res,
                       input logic [4:0] st);
        cycle(0, 1, tg, res, st, 0, 0, 0);
    endtask

    initial begin
        rst_n = 0; flush = 0; alloc_valid = 0; fpu_valid = 0;
        fpu_tag = '0; fpu_result = '0; fpu_status = '0;
        out_ready = 0; fflags_clr = 0;
        m_head = 0; m_count = 0; m_fflags = '0; m_err = 0;
        foreach (m_done[i]) m_done[i] = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        check("rst_alloc_ready", 64'(alloc_ready), 64'd1);
        check("rst_alloc_tag", 64'(alloc_tag), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_fflags", 64'(fflags), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_fpu_ready", 64'(fpu_ready), 64'd1);

        // Out-of-order completion, in-order retire
        repeat (3) cycle(1, 0, '0, '0, '0, 0, 0, 0);
        cpl(2, 64'hC, 5'b0);
        check("ord_tag2_only", 64'(out_valid), 64'd0);
        cpl(0, 64'hA, 5'b0);
        cpl(1, 64'hB, 5'b0);
        check("ord_first", result, 64'hA);
        idle(1);
        check("ord_second", result, 64'hB);
        idle(1);
        check("ord_third", result, 64'hC);
        idle(1);
        check("ord_empty", 64'(empty), 64'd1);

        // Full, no pass-through, wrap
        cycle(0, 0, '0, '0, '0, 0, 0, 1);
        repeat (8) cycle(1, 0, '0, '0, '0, 0, 0, 0);
        check("full_ready", 64'(alloc_ready), 64'd0);
        cpl(0, 64'h11, 5'b0);
        cycle(1, 0, '0, '0, '0, 1, 0, 0);
        check("full_tag_after", 64'(alloc_tag), 64'd0);
        check("full_ready_after", 64'(alloc_ready), 64'd1);
        cycle(1, 0, '0, '0, '0, 0, 0, 0);
        check("wrap_full", 64'(alloc_ready), 64'd0);
        cycle(0, 0, '0, '0, '0, 0, 0, 1);

        // Sticky fflags and clear concurrent with retire
        repeat (2) cycle(1, 0, '0, '0, '0, 0, 0, 0);
        cpl(0, 64'h1, 5'b00001);
        cpl(1, 64'h2, 5'b10000);
        idle(1);
        idle(1);
        check("fflags_acc", 64'(fflags), 64'b10001);
        cycle(1, 0, '0, '0, '0, 0, 0, 0);
        cpl(2, 64'h3, 5'b00100);
        cycle(0, 0, '0, '0, '0, 1, 1, 0);
        check("fflags_clr_ret", 64'(fflags), 64'b00100);

        // Completion to an unallocated tag
        cycle(0, 0, '0, '0, '0, 0, 0, 1);
        repeat (3) cycle(1, 0, '0, '0, '0, 0, 0, 0);
        cpl(5, 64'hDEAD, 5'b0);
        check("err_set", 64'(err), 64'd1);
        check("err_no_valid", 64'(out_valid), 64'd0);
        cpl(0, 64'h20, 5'b0);
        cpl(1, 64'h21, 5'b0);
        cpl(2, 64'h22, 5'b0);
        check("err_ret0", result, 64'h20);
        idle(1);
        check("err_ret1", result, 64'h21);
        idle(1);
        check("err_ret2", result, 64'h22);
        idle(1);

        // Stall stability
        cycle(1, 0, '0, '0, '0, 0, 0, 0);
        cpl(3, 64'h1234, 5'b01010);
        for (int i = 0; i < 10; i++) begin
            idle(0);
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_result", result, 64'h1234);
            check("stall_status", 64'(status), 64'b01010);
        end
        idle(1);
        check("stall_release", 64'(empty), 64'd1);

        // Flush with concurrent completion
        repeat (4) cycle(1, 0, '0, '0, '0, 0, 0, 0);
        cpl(4, 64'h40, 5'b00010);
        cpl(6, 64'h42, 5'b00010);
        cycle(0, 1, 5, 64'h41, 5'b00001, 0, 0, 1);
        check("flush_empty", 64'(empty), 64'd1);
        check("flush_valid", 64'(out_valid), 64'd0);
        check("flush_tag", 64'(alloc_tag), 64'd0);
        check("flush_fflags", 64'(fflags), 64'b01110);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            bit av, fv, ordy, clr, fl;
            logic [TW-1:0] tg;
            int start;
            fl   = ($urandom_range(0, 63) == 0);
            clr  = !fl && ($urandom_range(0, 15) == 0);
            av   = ($urandom_range(0, 2) != 0);
            fv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            tg   = TW'($urandom_range(0, D - 1));
            if (m_count > 0 && $urandom_range(0, 15) != 0) begin
                start = $urandom_range(0, m_count - 1);
                for (int i = 0; i < m_count; i++) begin
                    int k;
                    k = (m_head + (start + i) % m_count) % D;
                    if (!m_done[k]) begin
                        tg = TW'(k);
                        break;
                    end
                end
            end
            cycle(av, fv, tg, {$urandom, $urandom}, 5'($urandom), ordy, clr, fl);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fpnew_reorder_buffer.md
# fpnew_reorder_buffer

In-order writeback stage directly downstream of the FPU top level. Operation groups complete out of order because their pipeline depths differ. This block allocates a tag per issued operation and captures completions by tag. It releases results to the register-file writeback port strictly in issue order. It also accumulates the sticky IEEE exception flags (fflags) of retired operations.

## Interface
Parameters:
- `Width`, 64, result width; equals FPU `WIDTH`.
- `Depth`, 8, number of entries; power of two, 2..32.
- `TagWidth`, `$clog2(Depth)`, localparam; tag width, do not override.

Ports:
- `clk_i` in 1: clock. One clock domain.
- `rst_ni` in 1: asynchronous active-low reset.
- `flush_i` in 1: synchronous flush of all entries.
- `alloc_valid_i` in 1: issue side requests a tag.
- `alloc_ready_o` out 1: an entry is free.
- `alloc_tag_o` out TagWidth: tag granted; it is passed to the FPU as `tag_i`.
- `fpu_valid_i` in 1: FPU `out_valid_o`.
- `fpu_ready_o` out 1: FPU `out_ready_i`. Constant 1; the buffer never back-pressures completions.
- `fpu_result_i` in Width: FPU result.
- `fpu_status_i` in 5: FPU status {NV,DZ,OF,UF,NX}.
- `fpu_tag_i` in TagWidth: FPU tag.
- `out_valid_o` out 1: head entry is complete.
- `out_ready_i` in 1: writeback accepts.
- `result_o` out Width: head result.
- `status_o` out 5: head status.
- `fflags_o` out 5: sticky accumulated flags.
- `fflags_clr_i` in 1: clear `fflags_o`.
- `empty_o` out 1: no allocated entries.
- `err_o` out 1: sticky; set when a completion targets an unallocated entry or an already-complete entry.

## Operation
- State per entry:
  - `done` bit (reset 0).
  - result and status storage (not reset).
- Pointers:
  - `wr_ptr` and `rd_ptr` are TagWidth+1 bits, with an extra wrap bit.
  - `empty` = pointers equal.
  - `full` = indices equal and wrap bits differ.
- Allocate:
  - `alloc_ready_o = !full`; `alloc_tag_o = wr_ptr[TagWidth-1:0]`.
  - On `alloc_valid_i & alloc_ready_o`, `wr_ptr` increments, wrapping modulo 2·Depth.
  - Full blocks allocation even if a retire happens in the same cycle; there is no pass-through.
- Complete: on `fpu_valid_i`, the entry is at index `fpu_tag_i`.
  - If the entry is allocated (index lies in [rd_ptr, wr_ptr) modulo wrap) and not done: store result and status, set `done`.
  - Otherwise: discard the data and set `err_o`.
- Retire:
  - `out_valid_o = !empty & done[rd_ptr]`.
  - `result_o` and `status_o` are read from the head entry; they are don't-care when `out_valid_o`=0.
  - On `out_valid_o & out_ready_i`:
    - clear `done[rd_ptr]`;
    - increment `rd_ptr`;
    - `fflags <= (fflags_clr_i ? 0 : fflags) | status_o`.
  - Without a retire, `fflags_clr_i` sets `fflags` to 0.
- Same-cycle events:
  - Allocate, complete (any entry) and retire may all occur in one cycle and are independent.
  - A completion into the head entry in the cycle it becomes head is retired no earlier than the next cycle.
  - A retire and an allocate of the same index in one cycle is legal only when not full; the new entry starts with `done`=0.
- Flush, at the next edge:
  - `rd_ptr = wr_ptr = 0`; all `done` cleared.
  - Completions and allocations in the flush cycle are dropped.
  - `fflags` and `err_o` are preserved.
  - The FPU must be flushed in the same cycle; any in-flight tags are then stale.
- `err_o` is cleared only by reset.

## Timing
- Reset values:
  - `alloc_ready_o`=1, `alloc_tag_o`=0.
  - `out_valid_o`=0, `empty_o`=1.
  - `fflags_o`=0, `err_o`=0.
  - `fpu_ready_o`=1.
- Completion to `out_valid_o`: 1 cycle when the entry is the head and the head is unblocked (completion registered at edge N, `out_valid_o` high after edge N).
- Throughput: one allocate, one complete and one retire per cycle.
- `out_valid_o` must stay stable and `result_o`/`status_o` unchanged while `out_ready_i`=0; they change only on retire, flush or reset.
- Combinational paths:
  - `alloc_ready_o`, `alloc_tag_o`, `out_valid_o`, `result_o` and `status_o` depend on registers only.
  - There is no combinational path from any input to any output.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous).

## Test plan
- Reset, allocate tags 0,1,2; complete 2, then 0, then 1 with results 0xC, 0xA, 0xB → retire order 0xA, 0xB, 0xC. `out_valid_o` is low while only tag 2 is done.
- Depth=8: allocate 8 → `alloc_ready_o`=0. Next, retire one while `alloc_valid_i`=1 → no allocation that cycle; next cycle tag 0 is granted with wrap bit toggled.
- Complete two entries with status 5'b00001 and 5'b10000, retire both → `fflags_o`=5'b10001. `fflags_clr_i` concurrent with a retire of status 5'b00100 → `fflags_o`=5'b00100.
- Complete tag 5 while only tags 0..2 are allocated → `err_o`=1, no entry changes, later retirements are unaffected.
- `out_ready_i`=0 for 10 cycles with the head done → `out_valid_o`, `result_o` and `status_o` are stable; raising `out_ready_i` → retire on that edge.
- Allocate 4, complete 2, assert `flush_i` with a concurrent completion → next cycle `empty_o`=1, `out_valid_o`=0, `alloc_tag_o`=0, `fflags_o` unchanged.
